// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: two write lanes, four read ports, reserve request
// and scoreboard status.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              we0_i, we1_i;
    logic [ADDR_W-1:0] wr_addr0_i, wr_addr1_i;
    logic [DATA_W-1:0] wr_data0_i, wr_data1_i;
    logic [ADDR_W-1:0] rd_addr0_i, rd_addr1_i, rd_addr2_i, rd_addr3_i;
    logic [DATA_W-1:0] rd_data0_o, rd_data1_o, rd_data2_o, rd_data3_o;
    logic              rsv_i;
    logic [ADDR_W-1:0] rsv_addr_i;
    logic              rd_pend0_o, rd_pend1_o, rd_pend2_o, rd_pend3_o;
    logic [ADDR_W:0]   pend_cnt_o;

    modport master (
        output we0_i, we1_i, wr_addr0_i, wr_addr1_i, wr_data0_i, wr_data1_i,
        output rd_addr0_i, rd_addr1_i, rd_addr2_i, rd_addr3_i, rsv_i, rsv_addr_i,
        input  rd_data0_o, rd_data1_o, rd_data2_o, rd_data3_o,
        input  rd_pend0_o, rd_pend1_o, rd_pend2_o, rd_pend3_o, pend_cnt_o
    );

    modport slave (
        input  we0_i, we1_i, wr_addr0_i, wr_addr1_i, wr_data0_i, wr_data1_i,
        input  rd_addr0_i, rd_addr1_i, rd_addr2_i, rd_addr3_i, rsv_i, rsv_addr_i,
        output rd_data0_o, rd_data1_o, rd_data2_o, rd_data3_o,
        output rd_pend0_o, rd_pend1_o, rd_pend2_o, rd_pend3_o, pend_cnt_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write lanes, four async read ports
// with optional write bypass, and a per-register pending scoreboard.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W-1:0] ra    [4];
    logic [DATA_W-1:0] rdata [4];
    logic [ADDR_W:0]   cnt;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Lane 1 is applied after lane 0 so it wins collisions; reserve is applied last
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (bus.we0_i && !is_zero(bus.wr_addr0_i)) begin
            mem_d[bus.wr_addr0_i]  = bus.wr_data0_i;
            pend_d[bus.wr_addr0_i] = 1'b0;
        end
        if (bus.we1_i && !is_zero(bus.wr_addr1_i)) begin
            mem_d[bus.wr_addr1_i]  = bus.wr_data1_i;
            pend_d[bus.wr_addr1_i] = 1'b0;
        end
        if (bus.rsv_i && !is_zero(bus.rsv_addr_i))
            pend_d[bus.rsv_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    assign ra[0] = bus.rd_addr0_i;
    assign ra[1] = bus.rd_addr1_i;
    assign ra[2] = bus.rd_addr2_i;
    assign ra[3] = bus.rd_addr3_i;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            rdata[k] = mem_q[ra[k]];
            if (BYPASS != 0) begin
                if (bus.we0_i && bus.wr_addr0_i == ra[k]) rdata[k] = bus.wr_data0_i;
                if (bus.we1_i && bus.wr_addr1_i == ra[k]) rdata[k] = bus.wr_data1_i;
            end
            if (is_zero(ra[k])) rdata[k] = '0;
        end
    end

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            cnt = cnt + {{ADDR_W{1'b0}}, pend_q[i]};
    end

    assign bus.rd_data0_o = rdata[0];
    assign bus.rd_data1_o = rdata[1];
    assign bus.rd_data2_o = rdata[2];
    assign bus.rd_data3_o = rdata[3];
    assign bus.rd_pend0_o = pend_q[ra[0]];
    assign bus.rd_pend1_o = pend_q[ra[1]];
    assign bus.rd_pend2_o = pend_q[ra[2]];
    assign bus.rd_pend3_o = pend_q[ra[3]];
    assign bus.pend_cnt_o = cnt;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A (ZERO_REG=1, BYPASS=1) and instance B
// (ZERO_REG=0, BYPASS=0) share stimulus and are checked against an array model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0, rsv = 1'b0;
    logic [4:0]  wa0 = '0, wa1 = '0, rsa = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic [4:0]  rda [4] = '{default: '0};
    bit          chk_on = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    logic [31:0] m_mem  [2][32];
    bit          m_pend [2][32];

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifa.we0_i = we0;      assign ifb.we0_i = we0;
    assign ifa.we1_i = we1;      assign ifb.we1_i = we1;
    assign ifa.wr_addr0_i = wa0; assign ifb.wr_addr0_i = wa0;
    assign ifa.wr_addr1_i = wa1; assign ifb.wr_addr1_i = wa1;
    assign ifa.wr_data0_i = wd0; assign ifb.wr_data0_i = wd0;
    assign ifa.wr_data1_i = wd1; assign ifb.wr_data1_i = wd1;
    assign ifa.rsv_i = rsv;      assign ifb.rsv_i = rsv;
    assign ifa.rsv_addr_i = rsa; assign ifb.rsv_addr_i = rsa;
    assign ifa.rd_addr0_i = rda[0]; assign ifb.rd_addr0_i = rda[0];
    assign ifa.rd_addr1_i = rda[1]; assign ifb.rd_addr1_i = rda[1];
    assign ifa.rd_addr2_i = rda[2]; assign ifb.rd_addr2_i = rda[2];
    assign ifa.rd_addr3_i = rda[3]; assign ifb.rd_addr3_i = rda[3];

    logic [31:0] o_rd   [2][4];
    logic        o_pend [2][4];
    logic [5:0]  o_cnt  [2];
    assign o_rd[0][0] = ifa.rd_data0_o; assign o_rd[0][1] = ifa.rd_data1_o;
    assign o_rd[0][2] = ifa.rd_data2_o; assign o_rd[0][3] = ifa.rd_data3_o;
    assign o_rd[1][0] = ifb.rd_data0_o; assign o_rd[1][1] = ifb.rd_data1_o;
    assign o_rd[1][2] = ifb.rd_data2_o; assign o_rd[1][3] = ifb.rd_data3_o;
    assign o_pend[0][0] = ifa.rd_pend0_o; assign o_pend[0][1] = ifa.rd_pend1_o;
    assign o_pend[0][2] = ifa.rd_pend2_o; assign o_pend[0][3] = ifa.rd_pend3_o;
    assign o_pend[1][0] = ifb.rd_pend0_o; assign o_pend[1][1] = ifb.rd_pend1_o;
    assign o_pend[1][2] = ifb.rd_pend2_o; assign o_pend[1][3] = ifb.rd_pend3_o;
    assign o_cnt[0] = ifa.pend_cnt_o;
    assign o_cnt[1] = ifb.pend_cnt_o;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // cfg 0: r0 hardwired and bypass on; cfg 1: plain r0, no bypass
    function automatic logic [31:0] exp_rd(input int cfg, input logic [4:0] a);
        if (cfg == 0 && a == 5'd0) return 32'h0;
        if (cfg == 0 && we1 && wa1 == a) return wd1;
        if (cfg == 0 && we0 && wa0 == a) return wd0;
        return m_mem[cfg][a];
    endfunction

    function automatic int exp_cnt(input int cfg);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[cfg][i]);
        return c;
    endfunction

    initial begin
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 32; i++) begin
                m_mem[c][i] = '0;
                m_pend[c][i] = 1'b0;
            end
    end

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst_n) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[c][i] = '0;
                    m_pend[c][i] = 1'b0;
                end
            end else begin
                if (we0 && !(c == 0 && wa0 == 0)) begin m_mem[c][wa0] = wd0; m_pend[c][wa0] = 1'b0; end
                if (we1 && !(c == 0 && wa1 == 0)) begin m_mem[c][wa1] = wd1; m_pend[c][wa1] = 1'b0; end
                if (rsv && !(c == 0 && rsa == 0)) m_pend[c][rsa] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("rd_data%0d[%s]", k, c == 0 ? "A" : "B"), 64'(o_rd[c][k]), 64'(exp_rd(c, rda[k])));
                    chk($sformatf("rd_pend%0d[%s]", k, c == 0 ? "A" : "B"), 64'(o_pend[c][k]), 64'(m_pend[c][rda[k]]));
                end
                chk($sformatf("pend_cnt[%s]", c == 0 ? "A" : "B"), 64'(o_cnt[c]), 64'(exp_cnt(c)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rsv = 0;
    endtask

    initial begin
        tick();
        rst_n = 1'b1;
        chk_on = 1'b1;

        // reset clears preloaded contents
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; tick(); idle();
        rda[0] = 5; #1;
        chk("preload_r5_A", 64'(ifa.rd_data0_o), 64'hDEADBEEF);
        rst_n = 0; tick(); rst_n = 1; #1;
        chk("reset_r5_A", 64'(ifa.rd_data0_o), 64'h0);
        chk("reset_r5_B", 64'(ifb.rd_data0_o), 64'h0);
        chk("reset_cnt_A", 64'(ifa.pend_cnt_o), 64'd0);

        // write collision, lane 1 wins
        we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h11111111; wd1 = 32'h22222222;
        rda[1] = 7; #1;
        chk("coll_bypass_A", 64'(ifa.rd_data1_o), 64'h22222222);
        tick(); idle(); #1;
        chk("coll_after_A", 64'(ifa.rd_data1_o), 64'h22222222);
        chk("coll_after_B", 64'(ifb.rd_data1_o), 64'h22222222);

        // zero register
        we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; rsv = 1; rsa = 0;
        for (int k = 0; k < 4; k++) rda[k] = 0;
        tick(); idle(); #1;
        chk("zero_rd0_A", 64'(ifa.rd_data0_o), 64'h0);
        chk("zero_rd3_A", 64'(ifa.rd_data3_o), 64'h0);
        chk("zero_pend_A", 64'(ifa.rd_pend0_o), 64'd0);
        chk("zero_cnt_A", 64'(ifa.pend_cnt_o), 64'd0);
        chk("zero_rd0_B", 64'(ifb.rd_data0_o), 64'hFFFFFFFF);
        chk("zero_cnt_B", 64'(ifb.pend_cnt_o), 64'd1);

        // bypass off on B, on for A
        we0 = 1; wa0 = 3; wd0 = 32'hA; tick();
        wd0 = 32'hB; rda[2] = 3; #1;
        chk("nobyp_during_B", 64'(ifb.rd_data2_o), 64'hA);
        chk("byp_during_A", 64'(ifa.rd_data2_o), 64'hB);
        tick(); idle(); #1;
        chk("nobyp_after_B", 64'(ifb.rd_data2_o), 64'hB);

        // scoreboard
        rst_n = 0; tick(); rst_n = 1;
        rsv = 1; rsa = 4; tick(); rsa = 9; tick(); rsa = 12; tick(); idle(); #1;
        chk("sb_cnt3_A", 64'(ifa.pend_cnt_o), 64'd3);
        we0 = 1; wa0 = 4; we1 = 1; wa1 = 9; wd0 = 32'h4; wd1 = 32'h9; tick(); idle();
        rda[3] = 12; #1;
        chk("sb_cnt1_A", 64'(ifa.pend_cnt_o), 64'd1);
        chk("sb_pend12_A", 64'(ifa.rd_pend3_o), 64'd1);
        rsv = 1; rsa = 12; we0 = 1; wa0 = 12; wd0 = 32'hC; tick(); idle(); #1;
        chk("sb_rsvwins_A", 64'(ifa.rd_pend3_o), 64'd1);
        chk("sb_cnt_keep_A", 64'(ifa.pend_cnt_o), 64'd1);

        // full count
        for (int i = 0; i < 32; i++) begin
            rsv = 1; rsa = 5'(i); tick();
        end
        idle(); #1;
        chk("full_cnt_B", 64'(ifb.pend_cnt_o), 64'd32);
        chk("full_cnt_A", 64'(ifa.pend_cnt_o), 64'd31);
        rst_n = 0; tick(); rst_n = 1; #1;
        chk("full_rst_B", 64'(ifb.pend_cnt_o), 64'd0);
        chk("full_rst_A", 64'(ifa.pend_cnt_o), 64'd0);

        // randomized traffic; narrow address ranges provoke collisions
        for (int n = 0; n < 3000; n++) begin
            bit narrow = ($urandom_range(0, 1) == 1);
            we0 = ($urandom_range(0, 2) != 0);
            we1 = ($urandom_range(0, 2) != 0);
            rsv = ($urandom_range(0, 1) == 1);
            wa0 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wa1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rsa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            for (int k = 0; k < 4; k++)
                rda[k] = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rst_n = ($urandom_range(0, 63) != 0);
            tick();
        end
        idle(); rst_n = 1;
        tick();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
